// File: rtl/seq_control_pkg.sv
// Shared opcode encodings, source-select constants and sizing helpers for the
// microprogram sequencer controller.
package seq_control_pkg;

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_CONT = 4'd1,
    OP_JMP  = 4'd2,
    OP_CALL = 4'd3,
    OP_RET  = 4'd4,
    OP_LDCT = 4'd5,
    OP_LOOP = 4'd6,
    OP_WAIT = 4'd7
  } uop_e;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_DIR = 2'b11;

  localparam int STACK_DEPTH_DEF = 4;

  // Bits needed to hold a depth count of 0..depth inclusive.
  function automatic int depth_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/seq_control_if.sv
// Control-store fields, live status and sequencer control lines between the
// microcode pipeline and the sequencer controller.
interface seq_control_if #(parameter int CTR_W = 8);
  logic [3:0]       uop;
  logic [2:0]       cond_sel;
  logic             cond_pol;
  logic [CTR_W-1:0] count_val;
  logic [7:0]       flags;
  logic             hold;
  logic             s1;
  logic             s0;
  logic             zero_n;
  logic             cin;
  logic             re_n;
  logic             fe_n;
  logic             pup;
  logic             ctr_zero;
  logic             stk_err;

  modport master (
    output uop, cond_sel, cond_pol, count_val, flags, hold,
    input  s1, s0, zero_n, cin, re_n, fe_n, pup, ctr_zero, stk_err
  );

  modport slave (
    input  uop, cond_sel, cond_pol, count_val, flags, hold,
    output s1, s0, zero_n, cin, re_n, fe_n, pup, ctr_zero, stk_err
  );
endinterface

// File: rtl/seq_cond_mux.sv
// Branch condition select: picks one live flag (bit 0 reads as always-true)
// and applies the requested polarity.
module seq_cond_mux (
  input  logic [7:0] i_flags,
  input  logic [2:0] i_sel,
  input  logic       i_pol,
  output logic       o_cond
);

  logic w_flag;

  assign w_flag = (i_sel == 3'd0) ? 1'b1 : i_flags[i_sel];
  assign o_cond = w_flag ^ i_pol;

endmodule

// File: rtl/seq_control.sv
// Microprogram sequencer controller: pipelines control-store fields and decodes
// them into source-select/stack/carry controls, tracking loop count and stack depth.
module seq_control
  import seq_control_pkg::*;
#(
  parameter int CTR_W       = 8,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
  seq_control_if.slave  bus
);

  localparam int DW = depth_w(STACK_DEPTH);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  logic [3:0]       r_uop;
  logic [2:0]       r_cond_sel;
  logic             r_cond_pol;
  logic [CTR_W-1:0] r_count_val;
  logic [CTR_W-1:0] r_ctr;
  logic [DW-1:0]    r_depth;
  logic             r_stk_err;

  logic       w_cond;
  logic       w_hold;
  logic       w_ctr_nz;
  logic [1:0] w_sel;
  logic       w_zero_n, w_cin, w_re_n, w_fe_n, w_pup;
  logic       w_push, w_pop, w_ld_ctr, w_dec_ctr, w_clr_depth;

  seq_cond_mux u_cond (
    .i_flags (bus.flags),
    .i_sel   (r_cond_sel),
    .i_pol   (r_cond_pol),
    .o_cond  (w_cond)
  );

  // Reset overrides a stall so the forced-zero microaddress is always visible.
  assign w_hold   = bus.hold & ~reset;
  assign w_ctr_nz = (r_ctr != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_uop       <= OP_JZ;
      r_cond_sel  <= 3'd0;
      r_cond_pol  <= 1'b0;
      r_count_val <= '0;
    end else if (!bus.hold) begin
      r_uop       <= bus.uop;
      r_cond_sel  <= bus.cond_sel;
      r_cond_pol  <= bus.cond_pol;
      r_count_val <= bus.count_val;
    end
  end

  always_comb begin
    w_sel       = SEL_PC;
    w_zero_n    = 1'b1;
    w_cin       = 1'b1;
    w_re_n      = 1'b1;
    w_fe_n      = 1'b1;
    w_pup       = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ld_ctr    = 1'b0;
    w_dec_ctr   = 1'b0;
    w_clr_depth = 1'b0;
    if (w_hold) begin
      w_cin = 1'b0;
    end else begin
      case (r_uop)
        OP_JZ: begin
          w_zero_n    = 1'b0;
          w_cin       = 1'b0;
          w_clr_depth = 1'b1;
        end
        OP_CONT: w_sel = SEL_PC;
        OP_JMP: begin
          if (w_cond) w_sel = SEL_DIR;
          else        w_sel = SEL_PC;
        end
        OP_CALL: begin
          if (w_cond) begin
            w_sel  = SEL_DIR;
            w_fe_n = 1'b0;
            w_pup  = 1'b1;
            w_push = 1'b1;
          end else begin
            w_sel = SEL_PC;
          end
        end
        OP_RET: begin
          if (w_cond) begin
            w_sel  = SEL_STK;
            w_fe_n = 1'b0;
            w_pop  = 1'b1;
          end else begin
            w_sel = SEL_PC;
          end
        end
        OP_LDCT: begin
          w_re_n   = 1'b0;
          w_ld_ctr = 1'b1;
        end
        OP_LOOP: begin
          if (w_ctr_nz) begin
            w_sel     = SEL_AR;
            w_dec_ctr = 1'b1;
          end else begin
            w_sel = SEL_PC;
          end
        end
        OP_WAIT: begin
          if (w_cond) w_cin = 1'b1;
          else        w_cin = 1'b0;
        end
        default: w_sel = SEL_PC;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ctr <= '0;
    end else if (w_ld_ctr) begin
      r_ctr <= r_count_val;
    end else if (w_dec_ctr) begin
      r_ctr <= r_ctr - CTR_W'(1);
    end
  end

  // Overflow/underflow leaves depth pinned and only raises the sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_depth   <= '0;
      r_stk_err <= 1'b0;
    end else if (w_clr_depth) begin
      r_depth <= '0;
    end else if (w_push) begin
      if (r_depth == DEPTH_MAX) r_stk_err <= 1'b1;
      else                      r_depth   <= r_depth + DW'(1);
    end else if (w_pop) begin
      if (r_depth == '0) r_stk_err <= 1'b1;
      else               r_depth   <= r_depth - DW'(1);
    end
  end

  assign bus.s1       = w_sel[1];
  assign bus.s0       = w_sel[0];
  assign bus.zero_n   = w_zero_n;
  assign bus.cin      = w_cin;
  assign bus.re_n     = w_re_n;
  assign bus.fe_n     = w_fe_n;
  assign bus.pup      = w_pup;
  assign bus.ctr_zero = ~w_ctr_nz;
  assign bus.stk_err  = r_stk_err;

endmodule

// File: tb/tb_seq_control.sv
// Self-checking bench for seq_control: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_seq_control;
  import seq_control_pkg::*;

  localparam int CW = 8;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  seq_control_if #(.CTR_W(CW)) bus ();

  seq_control #(.CTR_W(CW), .STACK_DEPTH(SD)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: last accepted instruction fields plus counter/depth/error.
  int m_op, m_sel, m_pol, m_cnt, m_ctr, m_depth;
  bit m_err;

  function automatic bit cond_of(input int sel, input int pol, input logic [7:0] fl);
    bit c;
    if (sel == 0) c = 1'b1;
    else          c = fl[sel];
    if (pol != 0) c = ~c;
    return c;
  endfunction

  // Expected {s1,s0,zero_n,cin,re_n,fe_n,pup,ctr_zero,stk_err}.
  function automatic logic [8:0] model_out(input int op, input int sel, input int pol,
                                           input int ctr, input logic [7:0] fl,
                                           input bit hld, input bit err);
    int src;
    bit zn, ci, re, fe, pu, c;
    logic [8:0] r;
    src = 0; zn = 1'b1; ci = 1'b1; re = 1'b1; fe = 1'b1; pu = 1'b0;
    c = cond_of(sel, pol, fl);
    if (hld) begin
      ci = 1'b0;
    end else begin
      case (op)
        0: begin zn = 1'b0; ci = 1'b0; end
        2: if (c) src = 3;
        3: if (c) begin src = 3; fe = 1'b0; pu = 1'b1; end
        4: if (c) begin src = 2; fe = 1'b0; end
        5: re = 1'b0;
        6: if (ctr != 0) src = 1;
        7: if (!c) ci = 1'b0;
        default: src = 0;
      endcase
    end
    r[8:7] = src[1:0];
    r[6] = zn; r[5] = ci; r[4] = re; r[3] = fe; r[2] = pu;
    r[1] = (ctr == 0);
    r[0] = err;
    return r;
  endfunction

  task automatic model_reset();
    m_op = 0; m_sel = 0; m_pol = 0; m_cnt = 0; m_ctr = 0; m_depth = 0; m_err = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // Single compare process: check outputs mid-cycle, advance model on the edge.
  initial begin : chk_proc
    logic [8:0] got, exp;
    int n_op, n_sel, n_pol, n_cnt, n_ctr, n_depth;
    bit n_err, c;
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      exp = model_out(m_op, m_sel, m_pol, m_ctr, bus.flags, bus.hold && !rst, m_err);
      got = {bus.s1, bus.s0, bus.zero_n, bus.cin, bus.re_n, bus.fe_n, bus.pup,
             bus.ctr_zero, bus.stk_err};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t op=%0d got=%b exp=%b", $time, m_op, got, exp);
      end
      n_op = m_op; n_sel = m_sel; n_pol = m_pol; n_cnt = m_cnt;
      n_ctr = m_ctr; n_depth = m_depth; n_err = m_err;
      if (!bus.hold) begin
        c = cond_of(m_sel, m_pol, bus.flags);
        case (m_op)
          0: n_depth = 0;
          3: if (c) begin
               if (m_depth == SD) n_err = 1'b1;
               else               n_depth = m_depth + 1;
             end
          4: if (c) begin
               if (m_depth == 0) n_err = 1'b1;
               else              n_depth = m_depth - 1;
             end
          5: n_ctr = m_cnt;
          6: if (m_ctr > 0) n_ctr = m_ctr - 1;
          default: n_ctr = m_ctr;
        endcase
        n_op = bus.uop; n_sel = bus.cond_sel; n_pol = bus.cond_pol; n_cnt = bus.count_val;
      end
      @(posedge clk);
      if (!rst) begin
        m_op = n_op; m_sel = n_sel; m_pol = n_pol; m_cnt = n_cnt;
        m_ctr = n_ctr; m_depth = n_depth; m_err = n_err;
      end
    end
  end

  // Present fields for the next instruction plus live flags/hold/reset for the
  // one currently registered, then return at mid-cycle for observation.
  task automatic cyc(input logic [3:0] op, input logic [2:0] sel, input logic pol,
                     input logic [7:0] cnt, input logic [7:0] fl, input logic hld,
                     input logic r);
    @(posedge clk);
    #1;
    bus.uop = op; bus.cond_sel = sel; bus.cond_pol = pol; bus.count_val = cnt;
    bus.flags = fl; bus.hold = hld; rst = r;
    @(negedge clk);
  endtask

  initial begin : stim
    logic [3:0] op;
    bus.uop = 4'd0; bus.cond_sel = 3'd0; bus.cond_pol = 1'b0; bus.count_val = 8'd0;
    bus.flags = 8'h00; bus.hold = 1'b0;

    // Reset state and first instruction after reset
    cyc(OP_JZ, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1);
    lit("rst_zero_n", bus.zero_n, 1'b0);
    lit("rst_cin", bus.cin, 1'b0);
    lit("rst_fe_n", bus.fe_n, 1'b1);
    lit("rst_re_n", bus.re_n, 1'b1);
    lit("rst_ctr_zero", bus.ctr_zero, 1'b1);
    lit("rst_stk_err", bus.stk_err, 1'b0);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    lit("post_rst_zero_n", bus.zero_n, 1'b0);
    lit("post_rst_cin", bus.cin, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
      lit("cont_s", {bus.s1, bus.s0}, 2'b00);
      lit("cont_cin", bus.cin, 1'b1);
      lit("cont_ctr_zero", bus.ctr_zero, 1'b1);
    end

    // Counted loop
    cyc(OP_LDCT, 3'd0, 1'b0, 8'd3, 8'h00, 1'b0, 1'b0);
    cyc(OP_LOOP, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    lit("ldct_re_n", bus.re_n, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(OP_LOOP, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
      lit("loop_s", {bus.s1, bus.s0}, 2'b01);
      lit("loop_ctr_zero", bus.ctr_zero, 1'b0);
    end
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    lit("loop_end_s", {bus.s1, bus.s0}, 2'b00);
    lit("loop_end_ctr_zero", bus.ctr_zero, 1'b1);

    // Stack overflow then underflow
    for (int i = 0; i < 12; i++) begin
      op = (i < 5) ? OP_CALL : ((i < 11) ? OP_RET : OP_CONT);
      cyc(op, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
      if (i >= 1 && i <= 5) begin
        lit("call_fe_n", bus.fe_n, 1'b0);
        lit("call_pup", bus.pup, 1'b1);
      end
      if (i >= 6) lit("ret_s", {bus.s1, bus.s0, bus.fe_n, bus.pup}, 4'b1000);
      if (i == 5) lit("stk_err_before_ovf", bus.stk_err, 1'b0);
      if (i == 6 || i == 11) lit("stk_err_sticky", bus.stk_err, 1'b1);
    end

    // WAIT on flag 3
    cyc(OP_WAIT, 3'd3, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    cyc(OP_WAIT, 3'd3, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    lit("wait_s_cin", {bus.s1, bus.s0, bus.cin}, 3'b000);
    cyc(OP_WAIT, 3'd3, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    lit("wait_s_cin", {bus.s1, bus.s0, bus.cin}, 3'b000);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h08, 1'b0, 1'b0);
    lit("wait_done_cin", bus.cin, 1'b1);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);

    // Inverted-condition jump, then the same jump under hold
    cyc(OP_JMP, 3'd2, 1'b1, 8'd0, 8'h00, 1'b0, 1'b0);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    lit("jmp_s", {bus.s1, bus.s0}, 2'b11);
    cyc(OP_JMP, 3'd2, 1'b1, 8'd0, 8'h00, 1'b0, 1'b0);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0);
    lit("hold_outs", {bus.s1, bus.s0, bus.cin, bus.fe_n, bus.zero_n, bus.re_n}, 6'b000111);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    lit("hold_frozen_jmp_s", {bus.s1, bus.s0}, 2'b11);

    // Reset in the middle of a CALL, then a RET must underflow
    cyc(OP_CALL, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1);
    lit("mid_rst_zero_n", bus.zero_n, 1'b0);
    lit("mid_rst_stk_err", bus.stk_err, 1'b0);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    cyc(OP_RET, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    lit("mid_rst_ret_fe_n", bus.fe_n, 1'b0);
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);
    lit("mid_rst_depth_zero", bus.stk_err, 1'b1);

    // Randomized traffic, stack ops weighted up
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 4) op = ($urandom_range(0, 1) == 1) ? OP_CALL : OP_RET;
      else                          op = 4'($urandom_range(0, 15));
      cyc(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 6)),
          8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
    end
    cyc(OP_CONT, 3'd0, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
